// File: rtl/shift_rows_if.sv
// shift_rows_if: byte-in / column-out bus of the AES ShiftRows stage.
//   master : environment side; drives the byte stream and accepts columns
//   slave  : the stage; accepts bytes and drives columns
//   in_valid/in_ready/in_byte/in_tag/in_last_round : byte-serial state input
//   out_valid/out_ready/out_col/out_col_idx/out_tag/out_last_round/out_eob : column output
interface shift_rows_if #(
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_byte;
    logic [TAG_W-1:0] in_tag;
    logic             in_last_round;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_col;
    logic [1:0]       out_col_idx;
    logic [TAG_W-1:0] out_tag;
    logic             out_last_round;
    logic             out_eob;

    modport master (
        output in_valid, in_byte, in_tag, in_last_round, out_ready,
        input  in_ready, out_valid, out_col, out_col_idx, out_tag, out_last_round, out_eob
    );

    modport slave (
        input  in_valid, in_byte, in_tag, in_last_round, out_ready,
        output in_ready, out_valid, out_col, out_col_idx, out_tag, out_last_round, out_eob
    );
endinterface

// File: rtl/shift_rows_stage.sv
// shift_rows_stage: collects a 16-byte AES state byte-serially (column-major,
// byte i = r + 4c), applies ShiftRows and emits one 32-bit column per beat.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : byte input handshake + tag/last-round (sampled on byte 0),
//                   column output handshake with column index, tag, flag, eob
// Build option: define SHIFT_ROWS_PINGPONG_EN for two state buffers so one
// block fills while the other drains; default is a single buffer.
module shift_rows_stage #(
    parameter int unsigned TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    shift_rows_if.slave bus
);

`ifdef SHIFT_ROWS_PINGPONG_EN
    localparam int unsigned NBUF = 2;
`else
    localparam int unsigned NBUF = 1;
`endif
    localparam logic PTR_STEP = (NBUF == 2) ? 1'b1 : 1'b0;

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [127:0]     buf_q [NBUF];
    logic [127:0]     buf_n [NBUF];
    logic [TAG_W-1:0] tag_q [NBUF];
    logic [TAG_W-1:0] tag_n [NBUF];
    logic             lr_q  [NBUF];
    logic             lr_n  [NBUF];
    logic [NBUF-1:0]  full_q, full_n;
    logic             wr_ptr_q, wr_ptr_n, rd_ptr_q, rd_ptr_n;
    logic [3:0]       cnt_q, cnt_n;
    logic             wr_en, rd_xfer, last_beat, load_first;

    logic             in_ready_q, in_ready_d;
    logic             valid_q, valid_d;
    logic [31:0]      col_q, col_d;
    logic [1:0]       idx_q, idx_d;
    logic [TAG_W-1:0] otag_q, otag_d;
    logic             olr_q, olr_d;
    logic             eob_q, eob_d;

    // Shifted column c: row r comes from source column (c + r) mod 4.
    function automatic logic [31:0] shift_col(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] col;
        logic [1:0]  src;
        col = '0;
        for (int r = 0; r < 4; r++) begin
            src = c + 2'(r);
            col[8*(3-r) +: 8] = s[8*(r + 4*32'(src)) +: 8];
        end
        return col;
    endfunction

    assign wr_en     = bus.in_valid & in_ready_q;
    assign rd_xfer   = valid_q & bus.out_ready;
    assign last_beat = (idx_q == 2'd3);

    // Buffer bookkeeping; buf_n is the write-through view so a block completing
    // this cycle can present column 0 on the next one.
    always_comb begin
        buf_n    = buf_q;
        tag_n    = tag_q;
        lr_n     = lr_q;
        full_n   = full_q;
        wr_ptr_n = wr_ptr_q;
        rd_ptr_n = rd_ptr_q;
        cnt_n    = cnt_q;
        if (wr_en) begin
            buf_n[wr_ptr_q][8*cnt_q +: 8] = bus.in_byte;
            if (cnt_q == 4'd0) begin
                tag_n[wr_ptr_q] = bus.in_tag;
                lr_n[wr_ptr_q]  = bus.in_last_round;
            end
            cnt_n = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                full_n[wr_ptr_q] = 1'b1;
                wr_ptr_n         = wr_ptr_q ^ PTR_STEP;
            end
        end
        if (rd_xfer && last_beat) begin
            full_n[rd_ptr_q] = 1'b0;
            rd_ptr_n         = rd_ptr_q ^ PTR_STEP;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // Next state: start draining whenever the read-side buffer holds a full block.
    always_comb begin
        state_d    = state_q;
        load_first = 1'b0;
        case (state_q)
            FILL: begin
                if (full_n[rd_ptr_n]) begin
                    state_d    = DRAIN;
                    load_first = 1'b1;
                end
            end
            DRAIN: begin
                if (rd_xfer && last_beat) begin
                    if (full_n[rd_ptr_n]) load_first = 1'b1;
                    else                  state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Output next values; everything holds unless a column is loaded or advanced.
    always_comb begin
        in_ready_d = ~full_n[wr_ptr_n];
        valid_d    = (state_d == DRAIN);
        col_d      = col_q;
        idx_d      = idx_q;
        otag_d     = otag_q;
        olr_d      = olr_q;
        eob_d      = eob_q;
        if (load_first) begin
            col_d  = shift_col(buf_n[rd_ptr_n], 2'd0);
            idx_d  = 2'd0;
            otag_d = tag_n[rd_ptr_n];
            olr_d  = lr_n[rd_ptr_n];
            eob_d  = 1'b0;
        end else if (rd_xfer && !last_beat) begin
            col_d = shift_col(buf_q[rd_ptr_q], idx_q + 2'd1);
            idx_d = idx_q + 2'd1;
            eob_d = (idx_q == 2'd2);
        end
    end

    // Control and output registers; buffer contents need no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 4'd0;
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            col_q      <= 32'd0;
            idx_q      <= 2'd0;
            otag_q     <= '0;
            olr_q      <= 1'b0;
            eob_q      <= 1'b0;
        end else begin
            full_q     <= full_n;
            wr_ptr_q   <= wr_ptr_n;
            rd_ptr_q   <= rd_ptr_n;
            cnt_q      <= cnt_n;
            in_ready_q <= in_ready_d;
            valid_q    <= valid_d;
            col_q      <= col_d;
            idx_q      <= idx_d;
            otag_q     <= otag_d;
            olr_q      <= olr_d;
            eob_q      <= eob_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_n;
        tag_q <= tag_n;
        lr_q  <= lr_n;
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = valid_q;
    assign bus.out_col        = col_q;
    assign bus.out_col_idx    = idx_q;
    assign bus.out_tag        = otag_q;
    assign bus.out_last_round = olr_q;
    assign bus.out_eob        = eob_q;

endmodule
